// File: rtl/serv_dbg_ctrl.sv
// serv_dbg_ctrl: debug halt/resume controller for the SERV core.
// Drains to an instruction boundary, then serially rewrites the PC.
//
// Ports:
//   clk, i_rst                 clock, synchronous active-high reset
//   i_dbg_halt_req/resume_req  level halt / resume requests
//   o_dbg_halted, o_dbg_err    halted status, one-cycle error pulse
//   i_dbg_pc_wr_valid/_ready   new-PC write handshake, i_dbg_pc value
//   o_dbg_pc_rd                PC captured at halt entry / after write
//   i_core_boundary            core is between instructions
//   i_ibus_adr                 current core PC
//   o_core_stall               blocks the next instruction fetch
//   o_dbg_active               core muxes the strobes below in
//   o_pc_en, o_debug_we        PC shift enable, debug write select
//   o_csr_pc                   serial new-PC bit, LSB first
//   o_cnt0, o_cnt2, o_cnt12to31 bit-position strobes
//
// Build option: define SERV_DBG_PC_READ_EN to keep the PC readback
// register; otherwise o_dbg_pc_rd is tied to zero.

module serv_dbg_ctrl #(
    parameter int unsigned DRAIN_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_dbg_halt_req,
    input  logic        i_dbg_resume_req,
    output logic        o_dbg_halted,
    output logic        o_dbg_err,
    input  logic        i_dbg_pc_wr_valid,
    output logic        o_dbg_pc_wr_ready,
    input  logic [31:0] i_dbg_pc,
    output logic [31:0] o_dbg_pc_rd,
    input  logic        i_core_boundary,
    input  logic [31:0] i_ibus_adr,
    output logic        o_core_stall,
    output logic        o_dbg_active,
    output logic        o_pc_en,
    output logic        o_debug_we,
    output logic        o_csr_pc,
    output logic        o_cnt0,
    output logic        o_cnt2,
    output logic        o_cnt12to31
);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED,
        S_SHIFT
    } state_t;

    // Last DRAIN cycle index that still waits; the next miss aborts.
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);

    state_t      state;
    logic [4:0]  cnt;
    logic [7:0]  drain_cnt;
    logic [31:0] sreg;
    logic        err_q;
    logic        shifting;

    // Rotating right instead of plain shifting leaves the written
    // value back in sreg after 32 cycles, so no second copy is kept.
    logic [31:0] sreg_rot;
    assign sreg_rot = {sreg[0], sreg[31:1]};

`ifdef SERV_DBG_PC_READ_EN
    logic [31:0] pc_cap;
    assign o_dbg_pc_rd = pc_cap;
`else
    logic unused_ibus_adr;
    assign unused_ibus_adr = ^i_ibus_adr;
    assign o_dbg_pc_rd     = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state     <= S_RUN;
            cnt       <= 5'd0;
            drain_cnt <= 8'd0;
            sreg      <= 32'h0;
            err_q     <= 1'b0;
`ifdef SERV_DBG_PC_READ_EN
            pc_cap    <= 32'h0;
`endif
        end else begin
            err_q <= 1'b0;
            unique case (state)
                S_RUN: begin
                    if (i_dbg_halt_req) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 8'd0;
                    end
                end
                S_DRAIN: begin
                    if (i_core_boundary) begin
                        state <= S_HALTED;
`ifdef SERV_DBG_PC_READ_EN
                        pc_cap <= i_ibus_adr;
`endif
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                        if (drain_cnt == DRAIN_LAST) begin
                            err_q <= 1'b1;
                            state <= S_RUN;
                        end
                    end
                end
                S_HALTED: begin
                    // A write wins over a same-cycle resume.
                    if (i_dbg_pc_wr_valid) begin
                        if (i_dbg_pc[1:0] == 2'b00) begin
                            sreg  <= i_dbg_pc;
                            cnt   <= 5'd0;
                            state <= S_SHIFT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (i_dbg_resume_req) begin
                        state <= S_RUN;
                    end
                end
                S_SHIFT: begin
                    sreg <= sreg_rot;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= S_HALTED;
`ifdef SERV_DBG_PC_READ_EN
                        pc_cap <= sreg_rot;
`endif
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    // Everything below decodes registered state only.
    assign shifting          = (state == S_SHIFT);
    assign o_core_stall      = (state != S_RUN);
    assign o_dbg_halted      = (state == S_HALTED);
    assign o_dbg_pc_wr_ready = (state == S_HALTED);
    assign o_dbg_err         = err_q;
    assign o_dbg_active      = shifting;
    assign o_pc_en           = shifting;
    assign o_debug_we        = shifting;
    assign o_csr_pc          = shifting & sreg[0];
    assign o_cnt0            = shifting & (cnt == 5'd0);
    assign o_cnt2            = shifting & (cnt == 5'd2);
    assign o_cnt12to31       = shifting & (cnt >= 5'd12);

endmodule

// File: tb/tb_serv_dbg_ctrl.sv
// tb_serv_dbg_ctrl: directed bench for serv_dbg_ctrl.
// Hand-computed expectations plus a tiny serial-PC core model.

module tb_serv_dbg_ctrl;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_dbg_halt_req = 1'b0;
    logic        i_dbg_resume_req = 1'b0;
    logic        o_dbg_halted;
    logic        o_dbg_err;
    logic        i_dbg_pc_wr_valid = 1'b0;
    logic        o_dbg_pc_wr_ready;
    logic [31:0] i_dbg_pc = 32'h0;
    logic [31:0] o_dbg_pc_rd;
    logic        i_core_boundary = 1'b0;
    logic [31:0] i_ibus_adr = 32'h0000_0100;
    logic        o_core_stall;
    logic        o_dbg_active;
    logic        o_pc_en;
    logic        o_debug_we;
    logic        o_csr_pc;
    logic        o_cnt0;
    logic        o_cnt2;
    logic        o_cnt12to31;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] core_pc = 32'h0;
    logic [31:0] ser, en_m, c0_m, c2_m, c12_m;
    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    serv_dbg_ctrl #(.DRAIN_TIMEOUT(4)) dut (
        .clk               (clk),
        .i_rst             (i_rst),
        .i_dbg_halt_req    (i_dbg_halt_req),
        .i_dbg_resume_req  (i_dbg_resume_req),
        .o_dbg_halted      (o_dbg_halted),
        .o_dbg_err         (o_dbg_err),
        .i_dbg_pc_wr_valid (i_dbg_pc_wr_valid),
        .o_dbg_pc_wr_ready (o_dbg_pc_wr_ready),
        .i_dbg_pc          (i_dbg_pc),
        .o_dbg_pc_rd       (o_dbg_pc_rd),
        .i_core_boundary   (i_core_boundary),
        .i_ibus_adr        (i_ibus_adr),
        .o_core_stall      (o_core_stall),
        .o_dbg_active      (o_dbg_active),
        .o_pc_en           (o_pc_en),
        .o_debug_we        (o_debug_we),
        .o_csr_pc          (o_csr_pc),
        .o_cnt0            (o_cnt0),
        .o_cnt2            (o_cnt2),
        .o_cnt12to31       (o_cnt12to31)
    );

    // Core PC model: debug path shifts in csr_pc with bit 0 forced low.
    always @(posedge clk)
        if (o_pc_en && o_debug_we)
            core_pc <= {o_csr_pc & ~o_cnt0, core_pc[31:1]};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return 32'({o_dbg_halted, o_dbg_err, o_dbg_pc_wr_ready,
                    o_core_stall, o_dbg_active, o_pc_en, o_debug_we,
                    o_csr_pc, o_cnt0, o_cnt2, o_cnt12to31});
    endfunction

    initial begin
        step();
        step();
        check("rst_outs", outs(), 32'h0);
        check("rst_pc_rd", o_dbg_pc_rd, 32'h0);
        i_rst = 1'b0;
        step();
        check("run_stall", 32'(o_core_stall), 32'h0);

        // Halt: boundary in the 4th DRAIN cycle, same cycle as timeout.
        i_dbg_halt_req = 1'b1;
        step();
        i_dbg_halt_req = 1'b0;
        check("drain_stall", 32'(o_core_stall), 32'h1);
        check("drain_halted", 32'(o_dbg_halted), 32'h0);
        step();
        step();
        step();
        i_core_boundary = 1'b1;
        step();
        i_core_boundary = 1'b0;
        check("halt_halted", 32'(o_dbg_halted), 32'h1);
        check("halt_noerr", 32'(o_dbg_err), 32'h0);
        check("halt_ready", 32'(o_dbg_pc_wr_ready), 32'h1);
`ifdef SERV_DBG_PC_READ_EN
        exp_rd = 32'h0000_0100;
`else
        exp_rd = 32'h0;
`endif
        check("halt_pc_rd", o_dbg_pc_rd, exp_rd);

        // Misaligned write.
        i_dbg_pc_wr_valid = 1'b1;
        i_dbg_pc = 32'h0000_0102;
        step();
        i_dbg_pc_wr_valid = 1'b0;
        check("mis_err", 32'(o_dbg_err), 32'h1);
        check("mis_halted", 32'(o_dbg_halted), 32'h1);
        check("mis_active", 32'(o_dbg_active), 32'h0);
        step();
        check("mis_err_clr", 32'(o_dbg_err), 32'h0);

        // Aligned write 0x8000_0004; a resume mid-shift is ignored.
        i_dbg_pc_wr_valid = 1'b1;
        i_dbg_pc = 32'h8000_0004;
        step();
        i_dbg_pc_wr_valid = 1'b0;
        check("sh_ready", 32'(o_dbg_pc_wr_ready), 32'h0);
        ser = '0; en_m = '0; c0_m = '0; c2_m = '0; c12_m = '0;
        for (int i = 0; i < 32; i++) begin
            ser[i]   = o_csr_pc;
            en_m[i]  = o_pc_en & o_debug_we & o_dbg_active & o_core_stall;
            c0_m[i]  = o_cnt0;
            c2_m[i]  = o_cnt2;
            c12_m[i] = o_cnt12to31;
            i_dbg_resume_req = (i == 10);
            step();
        end
        i_dbg_resume_req = 1'b0;
        check("sh_serial", ser, 32'h8000_0004);
        check("sh_en", en_m, 32'hffff_ffff);
        check("sh_cnt0", c0_m, 32'h0000_0001);
        check("sh_cnt2", c2_m, 32'h0000_0004);
        check("sh_cnt12", c12_m, 32'hffff_f000);
        check("sh_back_halted", 32'(o_dbg_halted), 32'h1);
        check("sh_back_ready", 32'(o_dbg_pc_wr_ready), 32'h1);
        check("sh_back_pc_en", 32'(o_pc_en), 32'h0);
        check("sh_core_pc", core_pc, 32'h8000_0004);
`ifdef SERV_DBG_PC_READ_EN
        exp_rd = 32'h8000_0004;
`else
        exp_rd = 32'h0;
`endif
        check("sh_pc_rd", o_dbg_pc_rd, exp_rd);

        // Write and resume together: write wins, resume reissued.
        i_dbg_pc_wr_valid = 1'b1;
        i_dbg_resume_req = 1'b1;
        i_dbg_pc = 32'h0000_1000;
        step();
        i_dbg_pc_wr_valid = 1'b0;
        i_dbg_resume_req = 1'b0;
        check("wr_res_active", 32'(o_dbg_active), 32'h1);
        repeat (32) step();
        check("wr_res_halted", 32'(o_dbg_halted), 32'h1);
        check("wr_res_core_pc", core_pc, 32'h0000_1000);
        i_dbg_resume_req = 1'b1;
        step();
        i_dbg_resume_req = 1'b0;
        check("resume_stall", 32'(o_core_stall), 32'h0);
        check("resume_halted", 32'(o_dbg_halted), 32'h0);

        // Drain timeout after 4 DRAIN cycles.
        i_dbg_halt_req = 1'b1;
        step();
        i_dbg_halt_req = 1'b0;
        step();
        step();
        step();
        check("to_err_early", 32'(o_dbg_err), 32'h0);
        check("to_stall_early", 32'(o_core_stall), 32'h1);
        step();
        check("to_err", 32'(o_dbg_err), 32'h1);
        check("to_stall", 32'(o_core_stall), 32'h0);
        check("to_halted", 32'(o_dbg_halted), 32'h0);
        step();
        check("to_err_clr", 32'(o_dbg_err), 32'h0);

        // Reset in shift cycle 17.
        i_dbg_halt_req = 1'b1;
        step();
        i_dbg_halt_req = 1'b0;
        i_core_boundary = 1'b1;
        step();
        i_core_boundary = 1'b0;
        check("rh_halted", 32'(o_dbg_halted), 32'h1);
        i_dbg_pc_wr_valid = 1'b1;
        i_dbg_pc = 32'hdead_beec;
        step();
        i_dbg_pc_wr_valid = 1'b0;
        repeat (17) step();
        check("rs_cnt12", 32'(o_cnt12to31), 32'h1);
        check("rs_pc_en", 32'(o_pc_en), 32'h1);
        i_rst = 1'b1;
        step();
        check("rs_outs", outs(), 32'h0);
        check("rs_pc_rd", o_dbg_pc_rd, 32'h0);
        i_rst = 1'b0;
        step();
        check("rs_run", 32'(o_core_stall), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
